// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
// Every output is a register or a decode of registers.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic [15:0] baud_div,
    output logic        full,
    output logic        busy,
    output logic        overrun,
    output logic        uart_out,
    output logic        uart_stop
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic [15:0]   r_baud_cnt;
    logic          r_overrun;
    logic          r_uart_out;
    logic          r_uart_stop;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    state_t        w_state_nx;
    logic [15:0]   w_baud_nx;
    logic [7:0]    w_shift_nx;
    logic [2:0]    w_bit_nx;
    logic          w_out_nx;
    logic          w_stop_nx;
    logic          w_full;
    logic          w_wr_acc;
    logic          w_pop;
    logic          w_bit_end;
    logic [15:0]   w_baud_load;

    assign w_full      = (r_count == DEPTH_C);
    assign w_wr_acc    = wr_en & ~w_full;
    assign w_pop       = (r_state == S_IDLE) && (r_count != CNT_ZERO);
    assign w_bit_end   = (r_baud_cnt == 16'd0);
    // baud_div of zero behaves as one cycle per bit
    assign w_baud_load = (baud_div == 16'd0) ? 16'd0 : (baud_div - 16'd1);

    assign full      = w_full;
    assign busy      = (r_state != S_IDLE) || (r_count != CNT_ZERO);
    assign overrun   = r_overrun;
    assign uart_out  = r_uart_out;
    assign uart_stop = r_uart_stop;

    // Next-state, bit timing and next serial line value
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud_cnt;
        w_shift_nx = r_shift;
        w_bit_nx   = r_bit_cnt;
        w_out_nx   = 1'b1;
        w_stop_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nx = S_START;
                    w_baud_nx  = w_baud_load;
                    w_shift_nx = r_mem[r_rd_ptr];
                    w_bit_nx   = 3'd7;
                end else begin
                    w_baud_nx  = 16'd0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_baud_nx  = w_baud_load;
                end else begin
                    w_baud_nx  = r_baud_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nx = w_baud_load;
                    if (r_bit_cnt == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_bit_nx   = r_bit_cnt - 3'd1;
                        w_shift_nx = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_nx = r_baud_cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = S_STOP;
                    w_baud_nx  = w_baud_load;
                end else begin
                    w_baud_nx  = r_baud_cnt - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nx = S_IDLE;
                    w_baud_nx  = 16'd0;
                end else begin
                    w_baud_nx  = r_baud_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_baud_nx  = 16'd0;
            end
        endcase

        case (w_state_nx)
            S_START:  w_out_nx = 1'b0;
            S_DATA:   w_out_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_out_nx = r_parity;
`endif
            default:  w_out_nx = 1'b1;
        endcase
        // The pulse is registered, so it is raised on entry to the last stop cycle
        w_stop_nx = (w_state_nx == S_STOP) && (w_baud_nx == 16'd0);
    end

    // Transmitter state and registered line outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= 16'd0;
            r_shift     <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_uart_out  <= 1'b1;
            r_uart_stop <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_baud_cnt  <= w_baud_nx;
            r_shift     <= w_shift_nx;
            r_bit_cnt   <= w_bit_nx;
            r_uart_out  <= w_out_nx;
            r_uart_stop <= w_stop_nx;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte captured at pop time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^r_mem[r_rd_ptr];
        end else begin
            r_parity <= r_parity;
        end
    end
`endif

    // FIFO storage, pointers, occupancy and sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= CNT_ZERO;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overrun <= r_overrun | (wr_en & w_full);
        end
    end
endmodule
